// File: rtl/str_pkg.sv
// rtl/str_pkg.sv - shared state encoding and AXI constants for the stream-to-AXI burst splitter
package str_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CALC = 3'd1,
    ST_AW   = 3'd2,
    ST_DATA = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  localparam int         AXI_4K_BYTES = 4096;
  localparam logic [1:0] BRESP_OKAY   = 2'b00;

endpackage

// File: rtl/str_burst_split.sv
// rtl/str_burst_split.sv - splits a byte-addressed stream command into AXI write bursts
// Optional macro STR_BURST_SPLIT_4K_EN: keep every burst inside one 4 KB page.
module str_burst_split
  import str_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 24,
  parameter int MAX_BURST  = 16
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_cmd_vld,
  output logic                                o_cmd_rdy,
  input  logic [ADDR_WIDTH-1:0]               i_cmd_addr,
  input  logic [LEN_WIDTH-1:0]                i_cmd_len,
  input  logic [DATA_WIDTH-1:0]               s_axis_tdata,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    s_axis_tkeep,
  input  logic                                s_axis_tlast,
  input  logic                                s_axis_tvld,
  output logic                                s_axis_trdy,
  output logic [ADDR_WIDTH-1:0]               m_axi_awaddr,
  output logic [7:0]                          m_axi_awlen,
  output logic                                m_axi_awvalid,
  input  logic                                m_axi_awready,
  output logic [DATA_WIDTH-1:0]               m_axi_wdata,
  output logic [DATA_WIDTH/BYTE_WIDTH-1:0]    m_axi_wstrb,
  output logic                                m_axi_wlast,
  output logic                                m_axi_wvalid,
  input  logic                                m_axi_wready,
  input  logic [1:0]                          m_axi_bresp,
  input  logic                                m_axi_bvalid,
  output logic                                m_axi_bready,
  output logic                                o_done,
  output logic [1:0]                          o_err
);

  localparam int BYTE_CNT = DATA_WIDTH / BYTE_WIDTH;
  localparam int OFS_W    = $clog2(BYTE_CNT);
  localparam int BEAT_W   = LEN_WIDTH + 1;
  localparam int BURST_W  = 9;

  state_e                state;
  logic [ADDR_WIDTH-1:0] base;
  logic [BEAT_W-1:0]     remaining;
  logic [BEAT_W-1:0]     outstanding;
  logic [BURST_W-1:0]    burst_beats;
  logic [BURST_W-1:0]    beat_cnt;
  logic [1:0]            err;
  logic                  done;
  logic [BEAT_W-1:0]     cmd_total;
  logic                  in_data;
  logic                  aw_fire;
  logic                  w_fire;
  logic                  final_beat;

`ifdef STR_BURST_SPLIT_4K_EN
  function automatic logic [BURST_W-1:0] calc_burst(input logic [BEAT_W-1:0] rem,
                                                    input logic [ADDR_WIDTH-1:0] addr);
    logic [BEAT_W-1:0] lim;
    logic [12:0]       to_4k;
    lim   = (rem > BEAT_W'(MAX_BURST)) ? BEAT_W'(MAX_BURST) : rem;
    to_4k = (13'(AXI_4K_BYTES) - {1'b0, addr[11:0]}) >> OFS_W;
    if (BEAT_W'(to_4k) < lim) lim = BEAT_W'(to_4k);
    return BURST_W'(lim);
  endfunction
`else
  function automatic logic [BURST_W-1:0] calc_burst(input logic [BEAT_W-1:0] rem);
    logic [BEAT_W-1:0] lim;
    lim = (rem > BEAT_W'(MAX_BURST)) ? BEAT_W'(MAX_BURST) : rem;
    return BURST_W'(lim);
  endfunction
`endif

  // Beats touched by the command, counting the partial lead-in beat at the unaligned start.
  assign cmd_total = (BEAT_W'(i_cmd_addr[OFS_W-1:0]) + BEAT_W'(i_cmd_len)
                      + BEAT_W'(BYTE_CNT - 1)) >> OFS_W;

  assign in_data       = i_rst_n && (state == ST_DATA);
  assign o_cmd_rdy     = i_rst_n && (state == ST_IDLE);
  assign m_axi_awvalid = i_rst_n && (state == ST_AW);
  assign m_axi_awaddr  = base;
  assign m_axi_awlen   = 8'(burst_beats - 1'b1);
  assign m_axi_wvalid  = in_data & s_axis_tvld;
  assign s_axis_trdy   = in_data & m_axi_wready;
  assign m_axi_wdata   = s_axis_tdata;
  assign m_axi_wstrb   = s_axis_tkeep;
  assign m_axi_wlast   = in_data && (beat_cnt == burst_beats - 1'b1);
  assign m_axi_bready  = 1'b1;
  assign o_done        = done & i_rst_n;
  assign o_err         = err;

  assign aw_fire    = m_axi_awvalid & m_axi_awready;
  assign w_fire     = m_axi_wvalid & m_axi_wready;
  assign final_beat = m_axi_wlast && (remaining == BEAT_W'(burst_beats));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      base        <= '0;
      remaining   <= '0;
      outstanding <= '0;
      burst_beats <= '0;
      beat_cnt    <= '0;
      err         <= 2'b00;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (aw_fire && !m_axi_bvalid)
        outstanding <= outstanding + 1'b1;
      else if (!aw_fire && m_axi_bvalid && outstanding != '0)
        outstanding <= outstanding - 1'b1;

      case (state)
        ST_IDLE: begin
          if (i_cmd_vld) begin
            base      <= {i_cmd_addr[ADDR_WIDTH-1:OFS_W], {OFS_W{1'b0}}};
            remaining <= cmd_total;
            err       <= 2'b00;
            state     <= ST_CALC;
          end
        end
        ST_CALC: begin
`ifdef STR_BURST_SPLIT_4K_EN
          burst_beats <= calc_burst(remaining, base);
`else
          burst_beats <= calc_burst(remaining);
`endif
          state <= ST_AW;
        end
        ST_AW: begin
          if (aw_fire) begin
            beat_cnt <= '0;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_fire) begin
            if (s_axis_tlast != final_beat) err[0] <= 1'b1;
            if (m_axi_wlast) begin
              base      <= base + (ADDR_WIDTH'(burst_beats) << OFS_W);
              remaining <= remaining - BEAT_W'(burst_beats);
              state     <= (remaining != BEAT_W'(burst_beats)) ? ST_CALC : ST_RESP;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        ST_RESP: begin
          if (outstanding == '0) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Placed after the case so a bad response is never lost to the command-accept clear.
      if (m_axi_bvalid && m_axi_bresp != BRESP_OKAY) err[1] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_str_burst_split.sv
// tb/tb_str_burst_split.sv - randomized self-checking bench for str_burst_split
module tb_str_burst_split;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_cmd_vld;
  logic         o_cmd_rdy;
  logic [31:0]  i_cmd_addr;
  logic [23:0]  i_cmd_len;
  logic [511:0] s_axis_tdata;
  logic [63:0]  s_axis_tkeep;
  logic         s_axis_tlast;
  logic         s_axis_tvld;
  logic         s_axis_trdy;
  logic [31:0]  m_axi_awaddr;
  logic [7:0]   m_axi_awlen;
  logic         m_axi_awvalid;
  logic         m_axi_awready;
  logic [511:0] m_axi_wdata;
  logic [63:0]  m_axi_wstrb;
  logic         m_axi_wlast;
  logic         m_axi_wvalid;
  logic         m_axi_wready;
  logic [1:0]   m_axi_bresp;
  logic         m_axi_bvalid;
  logic         m_axi_bready;
  logic         o_done;
  logic [1:0]   o_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [511:0] bdata [0:127];
  logic [63:0]  bkeep [0:127];
  logic [31:0]  ex_addr [$];
  int           ex_len  [$];

  always #5 i_clk = ~i_clk;

  str_burst_split dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cmd_vld(i_cmd_vld), .o_cmd_rdy(o_cmd_rdy), .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvld(s_axis_tvld), .s_axis_trdy(s_axis_trdy),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .o_done(o_done), .o_err(o_err)
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    i_cmd_vld     = 1'b0;
    s_axis_tvld   = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b0;
    m_axi_bresp   = 2'd0;
  endtask

  // Burst plan from the splitting rules: 64-byte beats, at most 16 per burst, optional 4 KB pages.
  task automatic build_model(input logic [31:0] addr, input int len, output int total);
    logic [31:0] base;
    int rem, b, room;
    ex_addr.delete();
    ex_len.delete();
    base  = addr & ~32'h3f;
    total = (int'(addr % 64) + len + 63) / 64;
    rem   = total;
    while (rem > 0) begin
      b = (rem < 16) ? rem : 16;
`ifdef STR_BURST_SPLIT_4K_EN
      room = (4096 - int'(base % 4096)) / 64;
      if (room < b) b = room;
`else
      room = b;
`endif
      ex_addr.push_back(base);
      ex_len.push_back(b);
      base = base + 32'(b * 64);
      rem  = rem - b;
    end
    for (int i = 0; i < total; i++) begin
      for (int k = 0; k < 16; k++) bdata[i][k*32 +: 32] = $urandom;
      bkeep[i] = {$urandom, $urandom};
    end
  endtask

  task automatic run_cmd(input logic [31:0] addr, input int len, input int bad_beat,
                         input int aw_delay, input bit w_toggle, input int bresp_burst,
                         input int rst_burst, input int gap_pct);
    int total, nb, acc, aw_hs, wb, jb, bq, bi, aw_wait;
    bit tv, done_seen;
    logic [1:0] exp_err;
    build_model(addr, len, total);
    nb = ex_len.size();
    exp_err[0] = (bad_beat >= 0) && (bad_beat < total - 1);
    exp_err[1] = (bresp_burst >= 0) && (bresp_burst < nb);
    @(negedge i_clk);
    i_cmd_vld  = 1'b1;
    i_cmd_addr = addr;
    i_cmd_len  = 24'(len);
    #1 check("cmd_rdy", 512'(o_cmd_rdy), 512'(1));
    @(negedge i_clk);
    i_cmd_vld = 1'b0;
    acc = 0; aw_hs = 0; wb = 0; jb = 0; bq = 0; bi = 0; aw_wait = 0;
    tv = 1'b0; done_seen = 1'b0;
    for (int cyc = 0; cyc < 4000 && !done_seen; cyc++) begin
      if (cyc > 0) @(negedge i_clk);
      if (rst_burst >= 0 && aw_hs == rst_burst + 1 && jb >= 2) begin
        i_rst_n = 1'b0;
        idle_inputs();
        #1;
        check("rst_awvalid", 512'(m_axi_awvalid), 512'(0));
        check("rst_wvalid", 512'(m_axi_wvalid), 512'(0));
        check("rst_cmd_rdy", 512'(o_cmd_rdy), 512'(0));
        check("rst_trdy", 512'(s_axis_trdy), 512'(0));
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        check("post_rst_cmd_rdy", 512'(o_cmd_rdy), 512'(1));
        check("post_rst_err", 512'(o_err), 512'(0));
        check("post_rst_awvalid", 512'(m_axi_awvalid), 512'(0));
        return;
      end
      if (!tv && acc < total) tv = ($urandom_range(99) >= gap_pct);
      s_axis_tvld   = tv;
      s_axis_tdata  = bdata[acc];
      s_axis_tkeep  = bkeep[acc];
      s_axis_tlast  = (acc == total - 1) ^ (acc == bad_beat);
      m_axi_awready = m_axi_awvalid && (aw_wait >= aw_delay);
      if (m_axi_awvalid) aw_wait++;
      m_axi_wready  = w_toggle ? (cyc % 2 == 0) : 1'b1;
      m_axi_bvalid  = (bq > 0);
      m_axi_bresp   = (bi == bresp_burst) ? 2'd2 : 2'd0;
      #1;
      if (o_done) begin
        done_seen = 1'b1;
        check("aw_count", 512'(aw_hs), 512'(nb));
        check("beat_count", 512'(acc), 512'(total));
        check("b_count", 512'(bi), 512'(nb));
        check("err", 512'(o_err), 512'(exp_err));
      end
      if (m_axi_awvalid && m_axi_awready) begin
        if (aw_hs < nb) begin
          check("aw_addr", 512'(m_axi_awaddr), 512'(ex_addr[aw_hs]));
          check("aw_len", 512'(m_axi_awlen), 512'(ex_len[aw_hs] - 1));
        end else begin
          check("aw_extra", 512'(aw_hs), 512'(nb - 1));
        end
        aw_hs++;
        aw_wait = 0;
      end
      if (m_axi_wvalid) check("w_after_aw", 512'(aw_hs > wb), 512'(1));
      if (m_axi_wvalid && m_axi_wready) begin
        check("wdata", m_axi_wdata, bdata[acc]);
        check("wstrb", 512'(m_axi_wstrb), 512'(bkeep[acc]));
        if (wb < nb) check("wlast", 512'(m_axi_wlast), 512'(jb == ex_len[wb] - 1));
        else check("w_extra", 512'(wb), 512'(nb - 1));
        acc++;
        tv = 1'b0;
        jb++;
        if (wb < nb && jb == ex_len[wb]) begin
          jb = 0;
          wb++;
          bq++;
        end
      end
      if (m_axi_bvalid) begin
        bq--;
        bi++;
      end
    end
    idle_inputs();
    if (!done_seen) begin
      check("timeout", 512'(0), 512'(1));
    end else begin
      @(negedge i_clk);
      #1;
      check("done_pulse", 512'(o_done), 512'(0));
      check("idle_cmd_rdy", 512'(o_cmd_rdy), 512'(1));
    end
  endtask

  initial begin
    i_rst_n    = 1'b0;
    i_cmd_addr = '0;
    i_cmd_len  = '0;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    idle_inputs();
    @(negedge i_clk);
    @(negedge i_clk);
    #1;
    check("reset_cmd_rdy", 512'(o_cmd_rdy), 512'(0));
    check("reset_awvalid", 512'(m_axi_awvalid), 512'(0));
    check("reset_wvalid", 512'(m_axi_wvalid), 512'(0));
    check("reset_done", 512'(o_done), 512'(0));
    check("reset_trdy", 512'(s_axis_trdy), 512'(0));
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    check("release_cmd_rdy", 512'(o_cmd_rdy), 512'(1));
    check("release_err", 512'(o_err), 512'(0));
    check("bready", 512'(m_axi_bready), 512'(1));

    run_cmd(32'h0000_1000, 4096, -1, 0, 1'b0, -1, -1, 20);
    run_cmd(32'h0000_0F80, 256,  -1, 0, 1'b0, -1, -1, 0);
    run_cmd(32'h0000_2010, 100,  -1, 0, 1'b0, -1, -1, 0);
    run_cmd(32'h0000_3000, 256,   1, 0, 1'b0, -1, -1, 10);
    run_cmd(32'h0000_4000, 2048, -1, 5, 1'b1,  1, -1, 10);
    run_cmd(32'h0000_5000, 2048, -1, 1, 1'b0, -1,  1, 0);
    run_cmd(32'h0000_6040, 3000, -1, 2, 1'b1, -1, -1, 25);
    for (int t = 0; t < 6; t++) begin
      run_cmd($urandom & 32'h000F_FFFF, int'($urandom_range(3000, 1)), -1,
              int'($urandom_range(3)), 1'($urandom_range(1)), -1, -1, int'($urandom_range(40)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
